fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
Fetch sequencer that owns the architectural PC and drives the instruction-memory request port. It presents one fetched instruction at a time to decode, and accepts PC redirects from the branch unit (jump / taken beq target). It also handles decode stalls, flush on redirect, and discard of in-flight responses that a redirect has made stale.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
stall  input  1  decode cannot accept; hold the presented instruction.
redir_valid  input  1  one-cycle pulse: redirect PC to redir_target.
redir_target  input  32  redirect target address.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch address; word aligned.
imem_ack  input  1  request accepted and imem_rdata valid this cycle; sampled only while imem_req=1.
imem_rdata  input  32  fetched instruction.
if_valid  output  1  if_instr/if_pc valid to decode.
if_instr  output  32  presented instruction.
if_pc  output  32  PC of presented instruction.
if_pc_plus4  output  32  if_pc + 4, fed to branch unit.
misalign  output  1  sticky: a redirect target had nonzero bits [1:0].

Behaviour:
- Reset (rst=1 at posedge):
  - state=BOOT, pc=RESET_PC, kill=0, misalign=0.
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0.
  - rst mid-transaction abandons everything; a late imem_ack is ignored because req=0.
- State BOOT (one cycle): go to REQ with imem_addr=pc.
- State REQ: imem_req=1, imem_addr=pc, if_valid=0.
  - Addr stays stable until the imem_ack cycle; ack latency is variable (0..N cycles after req rises).
  - On ack with kill=0 and no redir_valid this cycle: capture if_instr=imem_rdata, if_pc=pc; go to RESP.
  - On ack with kill=1: discard rdata, pc=pending target, kill=0, stay in REQ (new address next cycle).
- State RESP: if_valid=1, imem_req=0.
  - stall=1: hold all outputs unchanged.
  - stall=0: pc=if_pc+4; go to REQ.
- Redirect rules (redir_valid=1; redirect beats stall):
  - BOOT: pc=target, go to REQ.
  - RESP: if_valid=0 next cycle regardless of stall; pc=target; go to REQ.
  - REQ with ack same cycle: discard rdata; pc=target; stay in REQ.
  - REQ without ack: kill=1, store target, keep addr stable. A second redirect before the ack overwrites the stored target (latest wins).
- Target alignment: the PC loaded is {target[31:2],2'b00}. If target[1:0]!=0, misalign<=1 and stays 1 until rst.
- Arithmetic: +4 is modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
- if_pc_plus4 = if_pc + 4, purely combinational from the if_pc register.
- Throughput: at most one instruction per 2 cycles (REQ then RESP) with zero-latency ack.
- imem_req only rises in REQ. It never drops before ack, except on rst.

Test Plan:
- Reset release, imem_ack tied 1, stall=0 → imem_addr 0x0,0x4,0x8 on cycles 1,3,5 after rst falls; if_valid on cycles 2,4,6 with matching if_pc; if_pc_plus4 = if_pc+4.
- Stall=1 for 3 cycles while if_valid=1 (if_pc=0x4) → if_instr/if_pc held, imem_req=0 throughout; first req after release at 0x8.
- redir_valid with redir_target=0x40 while in RESP and stall=1 → if_valid=0 next cycle; next imem_addr=0x40.
- Redirect to 0x80 while request at 0x8 is outstanding, ack delayed 3 cycles → imem_addr stays 0x8 until ack; that rdata never appears (if_valid stays 0); next req addr=0x80.
  - Repeat with a second redirect to 0xC0 before the ack → next req addr=0xC0.
- redir_target=0x102 → misalign=1 and stays 1; fetch address 0x100. After rst, misalign=0.
- RESET_PC=32'hFFFF_FFFC → second fetch addr 0x0. Then assert rst while a req is waiting for ack → imem_req=0 next cycle; the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Purpose  : Fetch sequencer. Owns the architectural PC, issues instruction
//            memory requests, presents one instruction at a time to decode,
//            and applies branch-unit redirects (including discarding stale
//            in-flight responses).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        misalign
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_kill;      // outstanding request was made stale by a redirect
   logic [31:0] r_tgt;       // where to fetch once the stale response returns
   logic        r_misalign;
   logic [31:0] r_if_instr;
   logic [31:0] r_if_pc;

   state_t      w_state_nx;
   logic [31:0] w_pc_nx;
   logic        w_kill_nx;
   logic [31:0] w_tgt_nx;
   logic        w_misalign_nx;
   logic [31:0] w_if_instr_nx;
   logic [31:0] w_if_pc_nx;
   logic [31:0] w_redir_pc;

   // Low two bits of a redirect target are dropped; the PC is always word aligned.
   assign w_redir_pc = {redir_target[31:2], 2'b00};

   // Next-state and next-datapath values; every target starts from its hold value.
   always_comb begin
      w_state_nx    = r_state;
      w_pc_nx       = r_pc;
      w_kill_nx     = r_kill;
      w_tgt_nx      = r_tgt;
      w_misalign_nx = r_misalign | (redir_valid & (redir_target[1:0] != 2'b00));
      w_if_instr_nx = r_if_instr;
      w_if_pc_nx    = r_if_pc;
      case (r_state)
         S_BOOT: begin
            w_state_nx = S_REQ;
            if (redir_valid) begin
               w_pc_nx = w_redir_pc;
            end
         end
         S_REQ: begin
            if (imem_ack) begin
               // Response arrives: a redirect this cycle or an earlier one
               // makes it stale, otherwise it goes to decode.
               w_kill_nx = 1'b0;
               if (redir_valid) begin
                  w_pc_nx = w_redir_pc;
               end else if (r_kill) begin
                  w_pc_nx = r_tgt;
               end else begin
                  w_if_instr_nx = imem_rdata;
                  w_if_pc_nx    = r_pc;
                  w_state_nx    = S_RESP;
               end
            end else if (redir_valid) begin
               // Address must stay stable until the ack, so park the target.
               w_kill_nx = 1'b1;
               w_tgt_nx  = w_redir_pc;
            end
         end
         S_RESP: begin
            if (redir_valid) begin
               w_pc_nx    = w_redir_pc;
               w_state_nx = S_REQ;
            end else if (!stall) begin
               w_pc_nx    = r_if_pc + 32'd4;
               w_state_nx = S_REQ;
            end
         end
         default: begin
            w_state_nx = S_BOOT;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_BOOT;
         r_pc       <= RESET_PC;
         r_kill     <= 1'b0;
         r_tgt      <= 32'd0;
         r_misalign <= 1'b0;
         r_if_instr <= 32'd0;
         r_if_pc    <= 32'd0;
      end else begin
         r_state    <= w_state_nx;
         r_pc       <= w_pc_nx;
         r_kill     <= w_kill_nx;
         r_tgt      <= w_tgt_nx;
         r_misalign <= w_misalign_nx;
         r_if_instr <= w_if_instr_nx;
         r_if_pc    <= w_if_pc_nx;
      end
   end

   assign imem_req    = (r_state == S_REQ);
   assign imem_addr   = r_pc;
   assign if_valid    = (r_state == S_RESP);
   assign if_instr    = r_if_instr;
   assign if_pc       = r_if_pc;
   assign if_pc_plus4 = r_if_pc + 32'd4;
   assign misalign    = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq
// Purpose  : Randomized scoreboard bench for fetch_seq. A transaction-level
//            model predicts request addresses and the instructions decode
//            should see; a separate monitor checks presentations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

   localparam logic [31:0] C_RESET_PC = 32'hFFFF_FFFC;
   localparam int          C_CYCLES   = 4000;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redir_valid;
   logic [31:0] redir_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        misalign;

   fetch_seq #(.RESET_PC(C_RESET_PC)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .if_valid     (if_valid),
      .if_instr     (if_instr),
      .if_pc        (if_pc),
      .if_pc_plus4  (if_pc_plus4),
      .misalign     (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } item_t;

   item_t q_exp[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
   endtask

   // Model of what the fetch unit is doing, expressed as transactions:
   // idle after reset, waiting on a fetch, or showing an instruction.
   typedef enum int {M_IDLE, M_FETCH, M_SHOW} mphase_t;
   mphase_t     m_phase;
   logic [31:0] m_pc;        // address of the current / next fetch
   bit          m_stale;     // outstanding fetch must be thrown away
   logic [31:0] m_after;     // where fetching resumes once it comes back
   bit          m_mis;
   logic [31:0] m_shown_pc;

   // Driver and request-side checks: inputs change on the falling edge.
   initial begin
      logic [31:0] t;
      rst = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'd0;
      imem_ack = 1'b0; imem_rdata = 32'd0;
      m_phase = M_IDLE; m_pc = C_RESET_PC; m_stale = 1'b0; m_after = 32'd0;
      m_mis = 1'b0; m_shown_pc = 32'd0;
      for (int cyc = 0; cyc < C_CYCLES; cyc++) begin
         @(negedge clk);
         chk("imem_req", {31'd0, imem_req}, {31'd0, m_phase == M_FETCH});
         if (m_phase == M_FETCH) chk("imem_addr", imem_addr, m_pc);
         chk("if_valid", {31'd0, if_valid}, {31'd0, m_phase == M_SHOW});
         chk("misalign", {31'd0, misalign}, {31'd0, m_mis});

         rst         = (cyc < 2) || ($urandom_range(0, 249) == 0);
         stall       = ($urandom_range(0, 1) == 0);
         imem_ack    = ($urandom_range(0, 9) < 5);
         imem_rdata  = $urandom;
         redir_valid = ($urandom_range(0, 7) == 0);
         t = 32'($urandom_range(0, 1023)) << 2;
         if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) t = t | 32'($urandom_range(1, 3));
         redir_target = t;

         if (rst) begin
            m_phase = M_IDLE; m_pc = C_RESET_PC; m_stale = 1'b0; m_mis = 1'b0;
         end else begin
            t = redir_target & 32'hFFFF_FFFC;
            if (redir_valid && redir_target[1:0] != 2'b00) m_mis = 1'b1;
            case (m_phase)
               M_IDLE: begin
                  if (redir_valid) m_pc = t;
                  m_phase = M_FETCH;
               end
               M_FETCH: begin
                  if (imem_ack) begin
                     if (redir_valid) begin
                        m_pc = t; m_stale = 1'b0;
                     end else if (m_stale) begin
                        m_pc = m_after; m_stale = 1'b0;
                     end else begin
                        q_exp.push_back('{pc: m_pc, instr: imem_rdata});
                        m_shown_pc = m_pc;
                        m_phase = M_SHOW;
                     end
                  end else if (redir_valid) begin
                     m_stale = 1'b1; m_after = t;
                  end
               end
               default: begin
                  if (redir_valid) begin
                     m_pc = t; m_phase = M_FETCH;
                  end else if (!stall) begin
                     m_pc = m_shown_pc + 32'd4; m_phase = M_FETCH;
                  end
               end
            endcase
         end
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("leftover_expected", 32'(q_exp.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Monitor: each new presentation pops the scoreboard; held ones must not change.
   initial begin
      bit          prev_valid = 1'b0;
      item_t       cur;
      cur = '0;
      forever begin
         @(posedge clk);
         #1;
         if (if_valid) begin
            if (!prev_valid) begin
               if (q_exp.size() == 0) begin
                  chk("unexpected_present", if_pc, 32'hDEAD_BEEF);
               end else begin
                  cur = q_exp.pop_front();
               end
            end
            chk("if_pc", if_pc, cur.pc);
            chk("if_instr", if_instr, cur.instr);
            chk("if_pc_plus4", if_pc_plus4, cur.pc + 32'd4);
         end
         prev_valid = if_valid;
      end
   end

endmodule
`default_nettype wire
